// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types for the divider front-end sequencer
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    UDIV = 2'd0,
    DIV  = 2'd1,
    UREM = 2'd2,
    REM  = 2'd3
  } div_opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } div_ctrl_state_e;

endpackage

// File: rtl/cv32e40p_div_norm.sv
// rtl/cv32e40p_div_norm.sv - divisor normalisation: leading-bit count, shift amount, pre-shifted divisor
module cv32e40p_div_norm #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic [C_WIDTH-1:0]     OpB_DI,
  input  logic                   Signed_SI,
  input  logic                   OpASign_SI,
  output logic [C_LOG_WIDTH-1:0] Shift_DO,
  output logic [C_WIDTH-1:0]     OpB_DO,
  output logic                   IsZero_SO
);

  logic                   NegB_S;
  logic [C_WIDTH-1:0]     Scan_D;
  logic [C_LOG_WIDTH-1:0] Lead_D;
  logic [C_LOG_WIDTH:0]   Sum_D;

  // A negative signed divisor counts leading ones, i.e. leading zeros of its complement.
  assign NegB_S = Signed_SI & OpB_DI[C_WIDTH-1];
  assign Scan_D = NegB_S ? ~OpB_DI : OpB_DI;

  always_comb begin
    Lead_D = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < C_WIDTH; i++) begin
      if (Scan_D[i]) begin
        Lead_D = C_LOG_WIDTH'(C_WIDTH - 1 - i);
      end
    end
  end

  // Leading-ones count is at least one for a negative divisor, so the subtraction cannot wrap.
  assign Sum_D = {1'b0, Lead_D}
               - {{C_LOG_WIDTH{1'b0}}, NegB_S}
               + {{C_LOG_WIDTH{1'b0}}, ~(Signed_SI & OpASign_SI)};

  assign Shift_DO  = (Sum_D > (C_LOG_WIDTH+1)'(C_WIDTH)) ? C_LOG_WIDTH'(C_WIDTH)
                                                         : Sum_D[C_LOG_WIDTH-1:0];
  assign OpB_DO    = OpB_DI << Shift_DO;
  assign IsZero_SO = (OpB_DI == '0);

endmodule

// File: rtl/cv32e40p_alu_div_ctrl.sv
// rtl/cv32e40p_alu_div_ctrl.sv - request/response sequencer for the serial divider; CV32E40P_DIV_FASTPATH_EN enables the trivial-case bypass
module cv32e40p_alu_div_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [1:0]             ReqOpCode_SI,
  input  logic                   Kill_SI,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  output logic                   DivOutRdy_SO,
  input  logic                   DivOutVld_SI,
  input  logic [C_WIDTH-1:0]     DivRes_DI,
  output logic                   RspVld_SO,
  input  logic                   RspRdy_SI,
  output logic [C_WIDTH-1:0]     RspRes_DO
);

  div_ctrl_state_e        State_SP, State_SN;
  div_opcode_e            ReqOp_S, OpCode_SP;
  logic [C_WIDTH-1:0]     OpA_DP, OpB_DP, Res_DP;
  logic [C_LOG_WIDTH-1:0] Shift_DP;
  logic                   IsZero_SP, Sign_SP;

  logic [C_LOG_WIDTH-1:0] NormShift_D;
  logic [C_WIDTH-1:0]     NormOpB_D;
  logic                   NormIsZero_S;
  logic                   Accept_S;
  logic                   FastHit_S;
  logic [C_WIDTH-1:0]     FastRes_D;

  assign ReqOp_S  = div_opcode_e'(ReqOpCode_SI);
  assign Accept_S = (State_SP == IDLE) && ReqVld_SI && !Kill_SI;

  cv32e40p_div_norm #(
    .C_WIDTH     (C_WIDTH),
    .C_LOG_WIDTH (C_LOG_WIDTH)
  ) i_div_norm (
    .OpB_DI     (ReqOpB_DI),
    .Signed_SI  (ReqOpCode_SI[0]),
    .OpASign_SI (ReqOpA_DI[C_WIDTH-1]),
    .Shift_DO   (NormShift_D),
    .OpB_DO     (NormOpB_D),
    .IsZero_SO  (NormIsZero_S)
  );

`ifdef CV32E40P_DIV_FASTPATH_EN
  // Negating INT_MIN wraps back to INT_MIN, which covers the signed overflow case.
  always_comb begin
    FastHit_S = 1'b0;
    FastRes_D = '0;
    if (ReqOpB_DI == '0) begin
      FastHit_S = 1'b1;
      FastRes_D = (ReqOp_S == UREM || ReqOp_S == REM) ? ReqOpA_DI : '1;
    end else if (ReqOpB_DI == C_WIDTH'(1)) begin
      FastHit_S = 1'b1;
      FastRes_D = (ReqOp_S == UREM || ReqOp_S == REM) ? '0 : ReqOpA_DI;
    end else if ((ReqOp_S == DIV || ReqOp_S == REM) && ReqOpB_DI == '1) begin
      FastHit_S = 1'b1;
      FastRes_D = (ReqOp_S == REM) ? '0 : C_WIDTH'(0) - ReqOpA_DI;
    end
  end
`else
  assign FastHit_S = 1'b0;
  assign FastRes_D = '0;
`endif

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      State_SP <= IDLE;
    end else begin
      State_SP <= State_SN;
    end
  end

  always_comb begin
    State_SN     = State_SP;
    ReqRdy_SO    = 1'b0;
    DivInVld_SO  = 1'b0;
    DivOutRdy_SO = 1'b0;
    RspVld_SO    = 1'b0;
    case (State_SP)
      IDLE: begin
        ReqRdy_SO = ~Kill_SI;
        if (Accept_S) begin
          State_SN = FastHit_S ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        DivInVld_SO = 1'b1;
        State_SN    = Kill_SI ? DRAIN : WAIT;
      end
      WAIT: begin
        DivOutRdy_SO = DivOutVld_SI;
        if (Kill_SI) begin
          State_SN = DRAIN;
        end else if (DivOutVld_SI) begin
          State_SN = RESP;
        end
      end
      RESP: begin
        RspVld_SO = ~Kill_SI;
        if (Kill_SI || RspRdy_SI) begin
          State_SN = IDLE;
        end
      end
      DRAIN: begin
        DivOutRdy_SO = 1'b1;
        if (DivOutVld_SI) begin
          State_SN = IDLE;
        end
      end
      default: State_SN = IDLE;
    endcase
  end

  // Operands are conditioned at acceptance so ISSUE drives registers only.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      OpA_DP    <= '0;
      OpB_DP    <= '0;
      Shift_DP  <= '0;
      IsZero_SP <= 1'b0;
      Sign_SP   <= 1'b0;
      OpCode_SP <= UDIV;
      Res_DP    <= '0;
    end else begin
      if (Accept_S) begin
        OpA_DP    <= ReqOpA_DI;
        OpB_DP    <= NormOpB_D;
        Shift_DP  <= NormShift_D;
        IsZero_SP <= NormIsZero_S;
        Sign_SP   <= ReqOpCode_SI[0] & ReqOpB_DI[C_WIDTH-1];
        OpCode_SP <= ReqOp_S;
        if (FastHit_S) begin
          Res_DP <= FastRes_D;
        end
      end
      if (State_SP == WAIT && DivOutVld_SI && !Kill_SI) begin
        Res_DP <= DivRes_DI;
      end
    end
  end

  assign DivOpA_DO       = OpA_DP;
  assign DivOpB_DO       = OpB_DP;
  assign DivOpBShift_DO  = Shift_DP;
  assign DivOpBIsZero_SO = IsZero_SP;
  assign DivOpBSign_SO   = Sign_SP;
  assign DivOpCode_SO    = OpCode_SP;
  assign RspRes_DO       = Res_DP;

endmodule

// File: tb/tb_cv32e40p_alu_div_ctrl.sv
// tb/tb_cv32e40p_alu_div_ctrl.sv - scoreboard bench for the divider sequencer with an attached behavioural divider
module tb_cv32e40p_alu_div_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ReqVld, ReqRdy, Kill;
  logic [31:0] ReqOpA, ReqOpB;
  logic [1:0]  ReqOpCode;
  logic [31:0] DivOpA, DivOpB, DivRes, RspRes;
  logic [5:0]  DivOpBShift;
  logic        DivOpBIsZero, DivOpBSign, DivInVld, DivOutRdy, DivOutVld;
  logic [1:0]  DivOpCode;
  logic        RspVld, RspRdy;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } rsp_t;

  rsp_t        rspQ[$];
  logic [73:0] condQ[$];
  int          nAssert = 0;
  int          nFail   = 0;
  int          cyc     = 0;
  int          rdyDelay = 0;
  logic [31:0] curA, curB;
  logic [1:0]  curOp;

  logic [1:0]  dState;
  logic [5:0]  dCnt;
  logic [31:0] dRes;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  cv32e40p_alu_div_ctrl dut (
    .Clk_CI          (Clk),
    .Rst_RI          (Rst),
    .ReqVld_SI       (ReqVld),
    .ReqRdy_SO       (ReqRdy),
    .ReqOpA_DI       (ReqOpA),
    .ReqOpB_DI       (ReqOpB),
    .ReqOpCode_SI    (ReqOpCode),
    .Kill_SI         (Kill),
    .DivOpA_DO       (DivOpA),
    .DivOpB_DO       (DivOpB),
    .DivOpBShift_DO  (DivOpBShift),
    .DivOpBIsZero_SO (DivOpBIsZero),
    .DivOpBSign_SO   (DivOpBSign),
    .DivOpCode_SO    (DivOpCode),
    .DivInVld_SO     (DivInVld),
    .DivOutRdy_SO    (DivOutRdy),
    .DivOutVld_SI    (DivOutVld),
    .DivRes_DI       (DivRes),
    .RspVld_SO       (RspVld),
    .RspRdy_SI       (RspRdy),
    .RspRes_DO       (RspRes)
  );

  function automatic logic [31:0] refDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : a % b;
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      default: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
    endcase
  endfunction

  // Behavioural serial divider: valid while idle, Shift+1 divide cycles, then FINISH.
  always @(posedge Clk) begin
    if (Rst) begin
      dState <= 2'd0;
      dCnt   <= '0;
      dRes   <= '0;
    end else begin
      case (dState)
        2'd0: if (DivInVld) begin
          dCnt   <= DivOpBShift;
          dRes   <= refDiv(curOp, curA, curB);
          dState <= 2'd1;
        end
        2'd1: if (dCnt == 0) dState <= 2'd2; else dCnt <= dCnt - 1;
        default: if (DivOutRdy) dState <= 2'd0;
      endcase
    end
  end
  assign DivOutVld = (dState == 2'd0) || (dState == 2'd2);
  assign DivRes    = dRes;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  // Response monitor: pops the scoreboard on the first valid cycle, then checks hold behaviour.
  initial begin
    rsp_t        e;
    logic [31:0] curExp;
    bit          inResp;
    int          held;
    inResp = 0;
    held   = 0;
    curExp = '0;
    RspRdy = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst || !RspVld) begin
        inResp = 0;
        RspRdy = 1'b0;
      end else begin
        if (!inResp) begin
          inResp = 1;
          held   = 0;
          if (rspQ.size() == 0) begin
            nAssert++;
            nFail++;
            $display("FAIL unexpected_rsp: got %0h required no response", RspRes);
            curExp = '0;
          end else begin
            e = rspQ.pop_front();
            check("rsp_latency", 128'(cyc - e.acc), 128'(e.lat));
            check("rsp_result", RspRes, e.res);
            curExp = e.res;
          end
        end else begin
          check("rsp_stable", RspRes, curExp);
          check("req_rdy_in_resp", ReqRdy, 1'b0);
        end
        RspRdy = (held >= rdyDelay);
        held++;
      end
    end
  end

  // Issue monitor: every divider launch must match a queued conditioning expectation.
  initial begin
    logic [73:0] exp;
    forever begin
      @(negedge Clk);
      if (!Rst && DivInVld) begin
        if (condQ.size() == 0) begin
          nAssert++;
          nFail++;
          $display("FAIL unexpected_issue: got DivInVld=1 required 0");
        end else begin
          exp = condQ.pop_front();
          check("issue_operands", {DivOpA, DivOpB, DivOpBShift, DivOpBIsZero, DivOpBSign, DivOpCode}, exp);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expLat,
                       input bit withCond, input logic [31:0] expOpB, input logic [5:0] expShift);
    int n;
    n = 0;
    @(negedge Clk);
    while (!ReqRdy && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!ReqRdy) begin
      nAssert++;
      nFail++;
      $display("FAIL req_timeout: got ReqRdy=0 required 1");
    end else begin
      ReqVld    = 1'b1;
      ReqOpA    = a;
      ReqOpB    = b;
      ReqOpCode = op;
      curA      = a;
      curB      = b;
      curOp     = op;
      if (expLat > 0) rspQ.push_back('{expRes, expLat, cyc});
      if (withCond) condQ.push_back({a, expOpB, expShift, (b == 0), op[0] & b[31], op});
      @(posedge Clk);
      #1;
      ReqVld = 1'b0;
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!(rspQ.size() == 0 && ReqRdy && !RspVld) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 300) begin
      nAssert++;
      nFail++;
      $display("FAIL done_timeout: got %0d pending required 0", rspQ.size());
    end
  endtask

  initial begin
    int bad;
    bit fin;
    Rst       = 1'b1;
    ReqVld    = 1'b0;
    ReqOpA    = '0;
    ReqOpB    = '0;
    ReqOpCode = '0;
    Kill      = 1'b0;
    curA      = '0;
    curB      = '0;
    curOp     = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs",
          {ReqRdy, DivInVld, DivOutRdy, RspVld, RspRes, DivOpA, DivOpB, DivOpBShift, DivOpBIsZero, DivOpBSign, DivOpCode},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0, 2'd0});
    @(negedge Clk);
    Rst = 1'b0;

    issue(2'd0, 32'd100, 32'd7, 32'd14, 34, 1, 32'hC000_0000, 6'd30);
    waitDone();
    issue(2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1, 32'h8000_0000, 6'd30);
    waitDone();
    issue(2'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1, 32'h8000_0000, 6'd30);
    waitDone();
`ifdef CV32E40P_DIV_FASTPATH_EN
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 32'h0, 6'd0);
    waitDone();
    issue(2'd2, 32'h1234, 32'h0, 32'h1234, 1, 0, 32'h0, 6'd0);
    waitDone();
    issue(2'd0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, 0, 32'h0, 6'd0);
    waitDone();
`else
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 1, 32'h8000_0000, 6'd31);
    waitDone();
    issue(2'd2, 32'h1234, 32'h0, 32'h1234, 36, 1, 32'h0, 6'd32);
    waitDone();
    issue(2'd0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 36, 1, 32'h0, 6'd32);
    waitDone();
`endif

    // Kill two cycles after ISSUE: DRAIN must keep DivOutRdy high until the divider finishes.
    issue(2'd0, 32'd100, 32'd7, 32'h0, 0, 1, 32'hC000_0000, 6'd30);
    repeat (3) @(negedge Clk);
    Kill = 1'b1;
    @(negedge Clk);
    Kill = 1'b0;
    bad  = 0;
    fin  = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      if (!DivOutRdy) bad++;
      if (dState == 2'd2) fin = 1;
      else @(negedge Clk);
    end
    check("kill_drain_rdy_low_cycles", 128'(bad), 128'd0);
    check("kill_divider_finished", fin, 1'b1);
    waitDone();
    issue(2'd0, 32'd9, 32'd3, 32'd3, 35, 1, 32'h8000_0000, 6'd31);
    waitDone();

    rdyDelay = 5;
    issue(2'd2, 32'd100, 32'd7, 32'd2, 34, 1, 32'hC000_0000, 6'd30);
    waitDone();
    rdyDelay = 0;

    issue(2'd0, 32'd100, 32'd7, 32'h0, 0, 1, 32'hC000_0000, 6'd30);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("reset_in_wait",
          {ReqRdy, DivInVld, DivOutRdy, RspVld, RspRes, DivOpA, DivOpB, DivOpBShift, DivOpBIsZero, DivOpBSign, DivOpCode},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0, 2'd0});
    @(negedge Clk);
    Rst = 1'b0;
    repeat (40) @(negedge Clk);

    check("rsp_queue_empty", 128'(rspQ.size()), 128'd0);
    check("issue_queue_empty", 128'(condQ.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion required $finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cv32e40p_alu_div_ctrl.md
# cv32e40p_alu_div_ctrl

Front-end sequencer for the serial divider `cv32e40p_alu_div`. It accepts divide/remainder requests from the ALU over a valid/ready handshake and registers the operands. It computes the normalisation shift, pre-shifted divisor and sign/zero flags, issues one operation to the divider, and captures its result into a response register held until the consumer accepts it.

## Interface
- `C_WIDTH`, 32, operand/result width
- `C_LOG_WIDTH`, 6, width of shift count; equals $clog2(C_WIDTH+1)

- `Clk_CI` in 1 clock, rising edge
- `Rst_RI` in 1 reset, synchronous, active-high
- `ReqVld_SI` in 1 request valid
- `ReqRdy_SO` out 1 request ready
- `ReqOpA_DI` in C_WIDTH dividend
- `ReqOpB_DI` in C_WIDTH divisor
- `ReqOpCode_SI` in 2 0 udiv, 1 div, 2 urem, 3 rem
- `Kill_SI` in 1 flush; abandons current operation
- `DivOpA_DO` out C_WIDTH to divider `OpA_DI`
- `DivOpB_DO` out C_WIDTH to divider `OpB_DI`, pre-shifted divisor
- `DivOpBShift_DO` out C_LOG_WIDTH to divider `OpBShift_DI`
- `DivOpBIsZero_SO` out 1 to divider `OpBIsZero_SI`
- `DivOpBSign_SO` out 1 to divider `OpBSign_SI`
- `DivOpCode_SO` out 2 to divider `OpCode_SI`
- `DivInVld_SO` out 1 to divider `InVld_SI`
- `DivOutRdy_SO` out 1 to divider `OutRdy_SI`
- `DivOutVld_SI` in 1 from divider `OutVld_SO`
- `DivRes_DI` in C_WIDTH from divider `Res_DO`
- `RspVld_SO` out 1 response valid
- `RspRdy_SI` in 1 response ready
- `RspRes_DO` out C_WIDTH result

## Operation
- **Reset values:** state IDLE. `ReqRdy_SO`=1 (IDLE). `DivInVld_SO`=0, `DivOutRdy_SO`=0, `RspVld_SO`=0, `RspRes_DO`=0. All `Div*_DO` outputs 0.
- **States:** IDLE, ISSUE, WAIT, RESP, DRAIN.
- **IDLE:**
  - `ReqRdy_SO`=1.
  - On `ReqVld_SI`: register A, B and opcode, then go to ISSUE.
  - If the fast path applies (see Configuration): go to RESP instead.
- **ISSUE:**
  - `DivInVld_SO`=1 for exactly one cycle, with the conditioned operands. Go to WAIT.
- **WAIT:**
  - `DivOutVld_SI` is ignored in ISSUE; the divider reports valid while idle.
  - On `DivOutVld_SI`: assert `DivOutRdy_SO` the same cycle, register `DivRes_DI` into `RspRes_DO`, go to RESP.
- **RESP:**
  - `RspVld_SO`=1; `RspRes_DO` stable until `RspRdy_SI`, then go to IDLE.
- **Kill:**
  - In ISSUE or WAIT: go to DRAIN.
  - In RESP: drop the response and go to IDLE.
  - In IDLE: block acceptance that cycle.
- **DRAIN:** hold `DivOutRdy_SO`=1; on `DivOutVld_SI`, discard the result and go to IDLE. No response is produced.
- **Conditioning:**
  - Signed = opcode[0]. `DivOpBSign_SO` = Signed & B[MSB].
  - Norm = number of leading zeros of B (unsigned or B≥0), or number of leading ones minus 1 (signed and B<0).
  - Shift = Norm + (Signed & A[MSB] ? 0 : 1), saturated to C_WIDTH.
  - `DivOpB_DO` = B << Shift, a logical shift.
  - `DivOpBIsZero_SO` = (B==0). `DivOpA_DO`=A. `DivOpCode_SO`=opcode.

## Timing
- Accept in cycle T.
- ISSUE is cycle T+1.
- The divider runs Shift+1 DIVIDE cycles and reaches FINISH at T+3+Shift. The result is captured there.
- `RspVld_SO` asserts at T+4+Shift.
- Fast-path latency: `RspVld_SO` at T+1.
- Back-to-back throughput: a new request is accepted no earlier than the cycle after the response handshake.
- `Kill_SI` and `RspRdy_SI` in the same RESP cycle: treated as kill. Outcome is identical (IDLE, no further response).
- Reset mid-operation returns to IDLE next cycle. The divider must share the same reset event; system reset drives both.

## Configuration
- `CV32E40P_DIV_FASTPATH_EN` defined: these cases bypass the divider (no `DivInVld_SO`) and go directly to RESP:
  - B==0: udiv/div → all ones; urem/rem → A.
  - Signed overflow (A=INT_MIN, B=-1): div → INT_MIN; rem → 0.
  - B==1: quotient A; remainder 0.
  - Signed B==-1 (no overflow): quotient −A; remainder 0.
- Undefined: all requests go through ISSUE/WAIT. Results are bit-identical to the fast-path results.

## Structure
- `cv32e40p_pkg` holds:
  - `div_opcode_e` (UDIV=0, DIV=1, UREM=2, REM=3).
  - `div_ctrl_state_e` (IDLE, ISSUE, WAIT, RESP, DRAIN).
- Sub-module `cv32e40p_div_norm`: combinational leading-bit counter plus left shifter. Produces Shift, pre-shifted B and IsZero.
- The divider is instantiated beside this block, not inside it.

## Test plan
- udiv A=100, B=7, bench divider attached → `RspRes_DO`=14; `RspVld_SO` exactly Shift+4 cycles after accept.
- rem A=-7 (0xFFFFFFF9), B=2 → 0xFFFFFFFF. div of the same operands → 0xFFFFFFFD.
- div A=0x80000000, B=0xFFFFFFFF → 0x80000000. With the macro: at T+1 and `DivInVld_SO` never asserted.
- urem A=0x1234, B=0 → 0x1234. udiv A=0x1234, B=0 → 0xFFFFFFFF, with and without the macro.
- Kill asserted two cycles after ISSUE → no response; `DivOutRdy_SO` high until the divider finishes; next request udiv 9/3 → 3.
- `RspRdy_SI` held low 5 cycles → `RspRes_DO` stable, `ReqRdy_SO`=0. Sync reset in WAIT → all outputs return to reset values next cycle.
